prog_loader: RTL and testbench

Upstream boot stage for the multicycle MIPS CPU. It receives a program image as a byte stream over a valid/ready channel and packs it into 32-bit words. It writes those words into the CPU's unified memory through a borrowed write port, checks an XOR checksum, and then releases the CPU from reset. While loading, it owns the memory write port; the top level muxes its address, data and write enable in front of the memory's address, data and write-enable inputs.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 20 ++
 rtl/prog_loader_word_packer.sv | 28 ++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int CSUM_W = 8;
  localparam int CNT_W  = 16;

  function automatic logic [CSUM_W-1:0] xor_fold(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream channel plus the borrowed memory write port of the loader.
interface prog_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_sel;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_wr, mem_sel
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_wr, mem_sel
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Packs big-endian stream bytes into 32-bit words; word is valid when word_full.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shreg_r;
  logic [1:0]  cnt_r;

  // Shift in accepted bytes; only the three older bytes need storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= 24'h00_0000;
      cnt_r   <= 2'd0;
    end else if (shift_en) begin
      shreg_r <= {shreg_r[15:0], data_byte};
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  assign word      = {shreg_r, data_byte};
  assign word_full = shift_en && (cnt_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte image, writes it
// to CPU memory word by word, then releases the CPU from reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_t            state_r;
  state_t            state_next;
  logic [7:0]        len_hi_r;
  logic [CNT_W-1:0]  n_r;
  logic [CNT_W-1:0]  idx_r;
  logic [CSUM_W-1:0] csum_r;
  logic              in_ready_r;
  logic              mem_wr_r;
  logic              mem_sel_r;
  logic [31:0]       mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              error_r;
  logic              accept;
  logic [CNT_W-1:0]  len_word;
  logic [31:0]       word;
  logic              word_full;

  assign accept   = bus.in_valid && in_ready_r;
  assign len_word = {len_hi_r, bus.in_data};

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (accept && (state_r == S_DATA)),
    .data_byte (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    state_next = state_r;
    case (state_r)
      S_LEN_HI: begin
        if (accept) state_next = S_LEN_LO;
        else        state_next = state_r;
      end
      S_LEN_LO: begin
        if (!accept)                  state_next = state_r;
        else if (len_word > MAX_N)    state_next = S_ERROR;
        else if (len_word == 16'd0)   state_next = S_CHECK;
        else                          state_next = S_DATA;
      end
      S_DATA: begin
        if (word_full) state_next = S_WRITE;
        else           state_next = state_r;
      end
      S_WRITE: begin
        if ((idx_r + 16'd1) == n_r) state_next = S_CHECK;
        else                        state_next = S_DATA;
      end
      S_CHECK: begin
        if (!accept)                        state_next = state_r;
        else if (bus.in_data == csum_r)     state_next = S_DONE;
        else                                state_next = S_ERROR;
      end
      S_DONE:  state_next = S_DONE;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // they are registered yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_LEN_HI;
      len_hi_r    <= 8'h00;
      n_r         <= 16'd0;
      idx_r       <= 16'd0;
      csum_r      <= 8'h00;
      in_ready_r  <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_sel_r   <= 1'b1;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'h0000_0000;
      cpu_hold_r  <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r    <= state_next;
      in_ready_r <= state_next inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
      mem_wr_r   <= (state_next == S_WRITE);
      mem_sel_r  <= (state_next != S_DONE);
      cpu_hold_r <= (state_next != S_DONE);
      done_r     <= (state_next == S_DONE);
      error_r    <= (state_next == S_ERROR);
      if (accept && (state_r == S_LEN_HI)) len_hi_r <= bus.in_data;
      if (accept && (state_r == S_LEN_LO)) n_r <= len_word;
      if (accept && (state_r inside {S_LEN_HI, S_LEN_LO, S_DATA}))
        csum_r <= xor_fold(csum_r, bus.in_data);
      if (word_full) begin
        mem_wdata_r <= word;
        mem_addr_r  <= BASE_ADDR + {{(30-CNT_W){1'b0}}, idx_r, 2'b00};
      end
      if (state_r == S_WRITE) idx_r <= idx_r + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_sel   = mem_sel_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0 and base 0x100) share one stream.
module tb_prog_loader;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       cpu_hold_a, done_a, error_a;
  logic       cpu_hold_b, done_b, error_b;

  int          n_cmp      = 0;
  int          n_err      = 0;
  int          ready_viol = 0;
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  logic [7:0]  stream[$];
  logic [31:0] exp_w[$];
  logic        exp_done;
  logic [4:0]  pre_flags;
  time         first_acc, last_acc;

  // flag vector order: {done, error, cpu_hold, mem_sel, in_ready}
  localparam logic [4:0] F_RESET = 5'b00110;
  localparam logic [4:0] F_BUSY  = 5'b00111;
  localparam logic [4:0] F_DONE  = 5'b10000;
  localparam logic [4:0] F_ERROR = 5'b01110;

  prog_loader_if bus_a ();
  prog_loader_if bus_b ();

  assign bus_a.in_data  = in_data;
  assign bus_a.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.in_valid = in_valid;

  prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
  );

  prog_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(64)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_a.mem_wr) begin
      wq_a.push_back({bus_a.mem_addr, bus_a.mem_wdata});
      if (bus_a.in_ready) ready_viol++;
    end
    if (bus_b.mem_wr) begin
      wq_b.push_back({bus_b.mem_addr, bus_b.mem_wdata});
      if (bus_b.in_ready) ready_viol++;
    end
  end

  function automatic logic [4:0] flags(input int d);
    return (d != 0) ? {done_b, error_b, cpu_hold_b, bus_b.mem_sel, bus_b.in_ready}
                    : {done_a, error_a, cpu_hold_a, bus_a.mem_sel, bus_a.in_ready};
  endfunction

  function automatic logic [64:0] port(input int d);
    return (d != 0) ? {bus_b.mem_wr, bus_b.mem_addr, bus_b.mem_wdata}
                    : {bus_a.mem_wr, bus_a.mem_addr, bus_a.mem_wdata};
  endfunction

  function automatic int nwr(input int d);
    return (d != 0) ? wq_b.size() : wq_a.size();
  endfunction

  function automatic logic [63:0] wr(input int d, input int i);
    return (d != 0) ? wq_b[i] : wq_a[i];
  endfunction

  function automatic logic [31:0] base(input int d);
    return (d != 0) ? 32'h0000_0100 : 32'h0000_0000;
  endfunction

  // Reference: parse the stream by its format rules.
  task automatic build_model();
    int         n;
    logic [7:0] acc;
    exp_w.delete();
    n   = int'({stream[0], stream[1]});
    acc = stream[0] ^ stream[1];
    exp_done = 1'b0;
    if (n > 64) return;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
      for (int k = 0; k < 4; k++) acc ^= stream[2+4*i+k];
    end
    exp_done = (stream[2+4*n] == acc);
  endtask

  task automatic make_random(input int n, input bit bad);
    logic [7:0]  acc;
    logic [31:0] w;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n > 64) return;
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      for (int k = 3; k >= 0; k--) stream.push_back(w[8*k +: 8]);
    end
    acc = 8'h00;
    foreach (stream[i]) acc ^= stream[i];
    if (bad) acc ^= 8'(1 << $urandom_range(7, 0));
    stream.push_back(acc);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    wq_a.delete();
    wq_b.delete();
    ready_viol = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int gap_max);
    int tries;
    for (int i = 0; i < stream.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = stream[i];
      tries    = 0;
      while (!bus_a.in_ready && tries < 100) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout byte %0d never accepted", i);
        in_valid = 1'b0;
        return;
      end
      if (i == stream.size() - 1) pre_flags = flags(0);
      @(posedge clk);
      if (i == 0) first_acc = $time;
      last_acc = $time;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (flags(d) !== F_RESET) begin
        n_err++;
        $display("FAIL reset_flags dut%0d got=%b exp=%b", d, flags(d), F_RESET);
      end
      n_cmp++;
      if (port(d) !== {1'b0, base(d), 32'h0000_0000}) begin
        n_err++;
        $display("FAIL reset_port dut%0d got=%h exp=%h", d, port(d), {1'b0, base(d), 32'h0});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (flags(d) !== F_BUSY) begin
        n_err++;
        $display("FAIL reset_release dut%0d got=%b exp=%b", d, flags(d), F_BUSY);
      end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    stream = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    build_model();
    send(0);
    @(negedge clk);
    n_cmp++;
    if (pre_flags !== F_BUSY) begin
      n_err++;
      $display("FAIL single_pre_check got=%b exp=%b", pre_flags, F_BUSY);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (flags(d) !== F_DONE) begin
        n_err++;
        $display("FAIL single_done dut%0d got=%b exp=%b", d, flags(d), F_DONE);
      end
      n_cmp++;
      if (nwr(d) !== exp_w.size()) begin
        n_err++;
        $display("FAIL single_wr_count dut%0d got=%0d exp=%0d", d, nwr(d), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < nwr(d); i++) begin
        n_cmp++;
        if (wr(d, i) !== {base(d) + 32'(4 * i), exp_w[i]}) begin
          n_err++;
          $display("FAIL single_wr dut%0d #%0d got=%h exp=%h", d, i, wr(d, i),
                   {base(d) + 32'(4 * i), exp_w[i]});
        end
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (flags(0) !== F_DONE) begin
      n_err++;
      $display("FAIL single_sticky got=%b exp=%b", flags(0), F_DONE);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    stream = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    build_model();
    send(0);
    n_cmp++;
    if (wq_a.size() !== 1) begin
      n_err++;
      $display("FAIL badsum_wr_count got=%0d exp=1", wq_a.size());
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (flags(d) !== F_ERROR) begin
          n_err++;
          $display("FAIL badsum_flags dut%0d cyc%0d got=%b exp=%b", d, c, flags(d), F_ERROR);
        end
      end
    end
  endtask

  task automatic test_empty();
    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    send(0);
    @(negedge clk);
    n_cmp++;
    if ({flags(0), flags(1)} !== {F_DONE, F_DONE}) begin
      n_err++;
      $display("FAIL empty_flags got=%b/%b exp=%b", flags(0), flags(1), F_DONE);
    end
    n_cmp++;
    if (wq_a.size() + wq_b.size() !== 0) begin
      n_err++;
      $display("FAIL empty_writes got=%0d exp=0", wq_a.size() + wq_b.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    stream = '{8'h00, 8'h41};
    send(0);
    @(negedge clk);
    n_cmp++;
    if ({flags(0), flags(1)} !== {F_ERROR, F_ERROR}) begin
      n_err++;
      $display("FAIL oversize_flags got=%b/%b exp=%b", flags(0), flags(1), F_ERROR);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wq_a.size() + wq_b.size() !== 0) begin
      n_err++;
      $display("FAIL oversize_writes got=%0d exp=0", wq_a.size() + wq_b.size());
    end
  endtask

  task automatic test_three_words();
    do_reset();
    stream = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h33, 8'h33, 8'h03};
    build_model();
    send(3);
    @(negedge clk);
    n_cmp++;
    if (ready_viol !== 0) begin
      n_err++;
      $display("FAIL three_ready_in_write got=%0d exp=0", ready_viol);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (flags(d) !== F_DONE) begin
        n_err++;
        $display("FAIL three_done dut%0d got=%b exp=%b", d, flags(d), F_DONE);
      end
      n_cmp++;
      if (nwr(d) !== exp_w.size()) begin
        n_err++;
        $display("FAIL three_wr_count dut%0d got=%0d exp=%0d", d, nwr(d), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < nwr(d); i++) begin
        n_cmp++;
        if (wr(d, i) !== {base(d) + 32'(4 * i), exp_w[i]}) begin
          n_err++;
          $display("FAIL three_wr dut%0d #%0d got=%h exp=%h", d, i, wr(d, i),
                   {base(d) + 32'(4 * i), exp_w[i]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    make_random(8, 1'b0);
    send(0);
    @(negedge clk);
    n_cmp++;
    if ((last_acc - first_acc) / 10 !== 64'(5 * 8 + 2)) begin
      n_err++;
      $display("FAIL b2b_cycles got=%0d exp=%0d", (last_acc - first_acc) / 10, 5 * 8 + 2);
    end
    n_cmp++;
    if ({flags(0), 32'(wq_a.size())} !== {F_DONE, 32'd8}) begin
      n_err++;
      $display("FAIL b2b_result flags=%b writes=%0d exp=%b/8", flags(0), wq_a.size(), F_DONE);
    end
  endtask

  task automatic test_random();
    int n;
    bit bad;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n   = ($urandom_range(7, 0) == 0) ? 64 + $urandom_range(3, 0) : $urandom_range(64, 0);
      bad = ($urandom_range(3, 0) == 0);
      make_random(n, bad);
      build_model();
      send($urandom_range(3, 0));
      @(negedge clk);
      n_cmp++;
      if (ready_viol !== 0) begin
        n_err++;
        $display("FAIL rand_ready_in_write it%0d got=%0d exp=0", it, ready_viol);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (flags(d) !== (exp_done ? F_DONE : F_ERROR)) begin
          n_err++;
          $display("FAIL rand_flags it%0d n=%0d dut%0d got=%b exp=%b", it, n, d, flags(d),
                   exp_done ? F_DONE : F_ERROR);
        end
        n_cmp++;
        if (nwr(d) !== exp_w.size()) begin
          n_err++;
          $display("FAIL rand_wr_count it%0d dut%0d got=%0d exp=%0d", it, d, nwr(d), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < nwr(d); i++) begin
          n_cmp++;
          if (wr(d, i) !== {base(d) + 32'(4 * i), exp_w[i]}) begin
            n_err++;
            $display("FAIL rand_wr it%0d dut%0d #%0d got=%h exp=%h", it, d, i, wr(d, i),
                     {base(d) + 32'(4 * i), exp_w[i]});
          end
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    send(0);
    n_cmp++;
    if ({32'(wq_a.size()), wq_a.size() > 0 ? wq_a[0] : 64'h0} !== {32'd1, 32'h0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL midload_first_word count=%0d", wq_a.size());
    end
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({flags(d), port(d)} !== {F_RESET, 1'b0, base(d), 32'h0000_0000}) begin
        n_err++;
        $display("FAIL midload_reset dut%0d got=%b/%h", d, flags(d), port(d));
      end
    end
    do_reset();
    make_random(1, 1'b0);
    build_model();
    send(1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (flags(d) !== F_DONE) begin
        n_err++;
        $display("FAIL midload_reload_done dut%0d got=%b exp=%b", d, flags(d), F_DONE);
      end
      n_cmp++;
      if (nwr(d) !== exp_w.size()) begin
        n_err++;
        $display("FAIL midload_wr_count dut%0d got=%0d exp=%0d", d, nwr(d), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < nwr(d); i++) begin
        n_cmp++;
        if (wr(d, i) !== {base(d) + 32'(4 * i), exp_w[i]}) begin
          n_err++;
          $display("FAIL midload_wr dut%0d #%0d got=%h exp=%h", d, i, wr(d, i),
                   {base(d) + 32'(4 * i), exp_w[i]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_empty();
    test_oversize();
    test_three_words();
    test_back_to_back();
    test_random();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
